sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one sram-like master port (the cpu_axi_interface slave side) between the core's instruction and data sram-like requesters.
- Sits between MiniMIPS32 and cpu_axi_interface, so the bridge sees a single in-order request stream.
- Grants by fixed data priority with an anti-starvation counter.
- Locks the grant until the address handshake completes, and routes responses back through an in-order source-ID FIFO.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (FIFO depth, power of 2, >=2).
- MAX_DSTREAK, 4, consecutive data grants allowed while inst is waiting before inst is forced.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- inst_req  in  1  instruction request
- inst_wr  in  1  instruction write
- inst_size  in  2  instruction size
- inst_addr  in  32  instruction address
- inst_wdata  in  32  instruction write data
- inst_rdata  out  32  instruction read data
- inst_addr_ok  out  1  instruction address accepted
- inst_data_ok  out  1  instruction data returned
- data_req  in  1  data request
- data_wr  in  1  data write
- data_size  in  2  data size
- data_addr  in  32  data address
- data_wdata  in  32  data write data
- data_rdata  out  32  data read data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data returned
- m_req  out  1  master request
- m_wr  out  1  master write
- m_size  out  2  master size
- m_addr  out  32  master address
- m_wdata  out  32  master write data
- m_rdata  in  32  master read data
- m_addr_ok  in  1  master address accepted
- m_data_ok  in  1  master data returned
- err_orphan  out  1  sticky: m_data_ok seen with FIFO empty

Behaviour:
- Reset (async, areset=1): state IDLE, FIFO empty, streak=0, err_orphan=0. All outputs are 0 with no requester active.
- States: IDLE, LOCK_I, LOCK_D.
  - In IDLE, select is combinational: data if data_req and not (inst_req and streak==MAX_DSTREAK); else inst if inst_req.
  - A selected request with no handshake this cycle moves to LOCK_I or LOCK_D. In LOCK, the selection is frozen to that source regardless of other requests.
  - On handshake (m_req & m_addr_ok), the state returns to IDLE next cycle.
- Request mux: m_wr/m_size/m_addr/m_wdata = selected source's fields, zero when none is selected.
  - m_req = selected source's req & !fifo_full.
  - Selected source's addr_ok = m_addr_ok & m_req; the unselected source's addr_ok = 0.
- FIFO:
  - Handshake pushes the source ID (0=inst, 1=data) at the posedge.
  - fifo_full uses the registered count only: a pop in the same cycle does not unblock a push (m_req stays 0 while count==OUTSTANDING).
- Response routing (combinational on FIFO head):
  - m_data_ok with count>0: asserts the head source's data_ok for that cycle with rdata=m_rdata, then pops. The other source's data_ok = 0; both rdata outputs = m_rdata.
  - m_data_ok with count==0: no data_ok asserted, err_orphan set (sticky until reset), FIFO unchanged.
- Simultaneous push and pop: count unchanged; the pointers advance modulo OUTSTANDING.
- Streak counter, updated on each handshake:
  - Data grant with inst_req high: streak = min(streak+1, MAX_DSTREAK).
  - Inst grant: streak = 0.
  - Data grant with inst_req low: streak = 0.
- Latency: zero-cycle request pass-through from req to m_req. Response pass-through is zero-cycle.
- Reset mid-transaction discards the FIFO. The bridge must be reset together with this block.

Test Plan:
- Single inst read at 0xBFC00000, m_addr_ok same cycle, m_data_ok 3 cycles later with m_rdata=0x3C010000 -> inst_addr_ok 1 cycle, inst_data_ok with inst_rdata=0x3C010000; data_data_ok stays 0.
- inst_req and data_req both held, m_addr_ok always 1, m_data_ok 2 cycles after each accept, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; responses routed to matching sources in order.
- data_req at cycle 0 with m_addr_ok low for 3 cycles, inst_req rising at cycle 1 -> m_addr stays data_addr until the handshake at cycle 3 (LOCK_D); inst is granted afterwards.
- OUTSTANDING=2, three back-to-back inst requests with no m_data_ok -> m_req drops after the second accept. With m_data_ok and a pending request in the same cycle, the third is not issued until the next cycle.
- m_data_ok pulse with FIFO empty -> no data_ok on either side, err_orphan=1 and held; areset pulse clears it to 0.
- areset asserted asynchronously mid-LOCK_I with 1 outstanding -> outputs go to 0 immediately, state IDLE, count=0 after release.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if
//   Bundle for one sram-like channel: request fields flow master -> slave,
//   address/data acknowledgements and read data flow slave -> master.
//   master modport : drives req, wr, size, addr, wdata; receives rdata, addr_ok, data_ok
//   slave modport  : receives req, wr, size, addr, wdata; drives rdata, addr_ok, data_ok
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Merges the instruction and data sram-like requesters of the core onto a
//   single sram-like master port, so the downstream bridge sees one in-order
//   request stream. Data has priority, but after MAX_DSTREAK consecutive data
//   grants with inst waiting, inst is forced through. Once a source is chosen
//   and not accepted in the same cycle, the grant is locked to it until its
//   address handshake. Accepted source IDs go into an in-order FIFO that routes
//   each m.data_ok back to the source that issued the request.
// Ports
//   aclk, areset : clock, asynchronous active-high reset
//   inst, data   : sram-like requester channels (slave side of this block)
//   m            : shared sram-like master channel towards the bridge
//   err_orphan   : sticky flag, m.data_ok arrived with no transaction outstanding
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    sram_like_arbiter_if.slave    inst,
    sram_like_arbiter_if.slave    data,
    sram_like_arbiter_if.master   m,
    output logic                  err_orphan
);

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;
    localparam int STK_W = $clog2(MAX_DSTREAK + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } state_e;

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [OUTSTANDING-1:0] fifo_id_r;      // 0 = inst, 1 = data
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [STK_W-1:0]       streak_r;
    logic                   err_orphan_r;

    logic sel_inst_s;
    logic sel_data_s;
    logic fifo_full_s;
    logic handshake_s;
    logic pop_s;
    logic orphan_s;
    logic head_id_s;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign fifo_full_s = (count_r == CNT_W'(OUTSTANDING));
    assign handshake_s = m.req & m.addr_ok;
    assign head_id_s   = fifo_id_r[rd_ptr_r];
    assign pop_s       = m.data_ok & (count_r != {CNT_W{1'b0}});
    assign orphan_s    = m.data_ok & (count_r == {CNT_W{1'b0}});
    assign err_orphan  = err_orphan_r;

    // FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: lock onto an unaccepted selection, release on handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (sel_inst_s) begin
                    state_nxt_s = ST_LOCK_I;
                end else if (sel_data_s) begin
                    state_nxt_s = ST_LOCK_D;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCK_I, ST_LOCK_D: begin
                if (handshake_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output: source selection (data first unless the streak limit forces inst).
    always_comb begin
        sel_inst_s = 1'b0;
        sel_data_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (data.req && !(inst.req && (streak_r == STK_W'(MAX_DSTREAK)))) begin
                    sel_data_s = 1'b1;
                end else if (inst.req) begin
                    sel_inst_s = 1'b1;
                end else begin
                    sel_inst_s = 1'b0;
                end
            end
            ST_LOCK_I: sel_inst_s = 1'b1;
            ST_LOCK_D: sel_data_s = 1'b1;
            default: begin
                sel_inst_s = 1'b0;
                sel_data_s = 1'b0;
            end
        endcase
    end

    // Request mux towards the master port and per-source acknowledgements.
    always_comb begin
        m.req         = 1'b0;
        m.wr          = 1'b0;
        m.size        = 2'd0;
        m.addr        = 32'd0;
        m.wdata       = 32'd0;
        if (sel_inst_s) begin
            m.req   = inst.req & ~fifo_full_s;
            m.wr    = inst.wr;
            m.size  = inst.size;
            m.addr  = inst.addr;
            m.wdata = inst.wdata;
        end else if (sel_data_s) begin
            m.req   = data.req & ~fifo_full_s;
            m.wr    = data.wr;
            m.size  = data.size;
            m.addr  = data.addr;
            m.wdata = data.wdata;
        end else begin
            m.req = 1'b0;
        end
        inst.addr_ok = sel_inst_s & handshake_s;
        data.addr_ok = sel_data_s & handshake_s;
        inst.data_ok = pop_s & ~head_id_s;
        data.data_ok = pop_s & head_id_s;
        inst.rdata   = m.rdata;
        data.rdata   = m.rdata;
    end

    // Source-ID FIFO: push on address handshake, pop on routed response.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            fifo_id_r <= {OUTSTANDING{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            if (handshake_s) begin
                fifo_id_r[wr_ptr_r] <= sel_data_s;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({handshake_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Data-streak counter: counts data grants that overtook a waiting inst request.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            streak_r <= {STK_W{1'b0}};
        end else if (handshake_s) begin
            if (sel_data_s && inst.req) begin
                if (streak_r != STK_W'(MAX_DSTREAK)) begin
                    streak_r <= streak_r + STK_W'(1);
                end
            end else begin
                streak_r <= {STK_W{1'b0}};
            end
        end
    end

    // Sticky orphan-response flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_orphan_r <= 1'b0;
        end else if (orphan_s) begin
            err_orphan_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter
//   Randomized and directed stimulus against a queue-based reference model of
//   the arbiter. The model tracks the lock owner, the streak count and the list
//   of outstanding source IDs, and predicts every output each cycle.
module tb_sram_like_arbiter;

    localparam int OUTSTANDING = 2;
    localparam int MAX_DSTREAK = 4;

    logic aclk;
    logic areset;
    logic err_orphan;

    sram_like_arbiter_if inst_if ();
    sram_like_arbiter_if data_if ();
    sram_like_arbiter_if m_if ();

    sram_like_arbiter #(
        .OUTSTANDING (OUTSTANDING),
        .MAX_DSTREAK (MAX_DSTREAK)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .inst       (inst_if),
        .data       (data_if),
        .m          (m_if),
        .err_orphan (err_orphan)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int lock_src = 0;      // 0 none, 1 inst, 2 data
    int streak_m = 0;
    bit q[$];              // outstanding source IDs, 0 inst / 1 data
    bit orphan_m = 1'b0;
    bit last_hs  = 1'b0;
    int last_sel = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lock_src = 0;
        streak_m = 0;
        orphan_m = 1'b0;
        last_hs  = 1'b0;
        last_sel = 0;
    endtask

    task automatic zero_inputs();
        inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd0;
        inst_if.addr = 32'd0; inst_if.wdata = 32'd0;
        data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd0;
        data_if.addr = 32'd0; data_if.wdata = 32'd0;
        m_if.rdata = 32'd0; m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; checks, crosses posedge, returns at next negedge.
    task automatic step();
        int sel;
        int qs;
        bit exp_req, hs, pop, head, dok;
        logic [31:0] exp_addr, exp_wdata;
        logic [2:0]  exp_ctl;
        #1;
        qs = q.size();
        if (lock_src != 0) sel = lock_src;
        else if (data_if.req && !(inst_if.req && streak_m == MAX_DSTREAK)) sel = 2;
        else if (inst_if.req) sel = 1;
        else sel = 0;
        exp_req   = ((sel == 1 && inst_if.req) || (sel == 2 && data_if.req)) && (qs < OUTSTANDING);
        exp_addr  = (sel == 1) ? inst_if.addr  : (sel == 2) ? data_if.addr  : 32'd0;
        exp_wdata = (sel == 1) ? inst_if.wdata : (sel == 2) ? data_if.wdata : 32'd0;
        exp_ctl   = (sel == 1) ? {inst_if.wr, inst_if.size} : (sel == 2) ? {data_if.wr, data_if.size} : 3'd0;
        hs   = exp_req && m_if.addr_ok;
        dok  = m_if.data_ok;
        pop  = dok && (qs > 0);
        head = (qs > 0) ? q[0] : 1'b0;
        check_val("m_req",        32'(m_if.req), 32'(exp_req));
        check_val("m_addr",       m_if.addr, exp_addr);
        check_val("m_wdata",      m_if.wdata, exp_wdata);
        check_val("m_wr_size",    32'({m_if.wr, m_if.size}), 32'(exp_ctl));
        check_val("inst_addr_ok", 32'(inst_if.addr_ok), 32'(hs && sel == 1));
        check_val("data_addr_ok", 32'(data_if.addr_ok), 32'(hs && sel == 2));
        check_val("inst_data_ok", 32'(inst_if.data_ok), 32'(pop && !head));
        check_val("data_data_ok", 32'(data_if.data_ok), 32'(pop && head));
        check_val("inst_rdata",   inst_if.rdata, m_if.rdata);
        check_val("data_rdata",   data_if.rdata, m_if.rdata);
        check_val("err_orphan",   32'(err_orphan), 32'(orphan_m));
        @(posedge aclk);
        if (pop) head = q.pop_front();
        if (hs) q.push_back(sel == 2);
        if (dok && qs == 0) orphan_m = 1'b1;
        if (hs) begin
            if (sel == 2 && inst_if.req) streak_m = (streak_m + 1 > MAX_DSTREAK) ? MAX_DSTREAK : streak_m + 1;
            else streak_m = 0;
            lock_src = 0;
        end else if (lock_src == 0 && sel != 0) begin
            lock_src = sel;
        end
        last_hs  = hs;
        last_sel = sel;
        @(negedge aclk);
    endtask

    // Reset with idle inputs; checks the in-reset outputs and returns at a negedge with reset released.
    task automatic do_reset();
        areset = 1'b1;
        zero_inputs();
        #1;
        check_val("rst_m_req",      32'(m_if.req), 32'd0);
        check_val("rst_m_addr",     m_if.addr, 32'd0);
        check_val("rst_err_orphan", 32'(err_orphan), 32'd0);
        check_val("rst_data_oks",   32'({inst_if.data_ok, data_if.data_ok}), 32'd0);
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    bit inst_pend, data_pend, d1, d2;
    int grants[$];
    int exp_grants[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    initial begin
        areset = 1'b1;
        zero_inputs();
        @(negedge aclk);
        do_reset();

        // single inst read, response three cycles after accept
        inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0000; m_if.addr_ok = 1'b1;
        step();
        inst_if.req = 1'b0; m_if.addr_ok = 1'b0;
        step();
        step();
        m_if.data_ok = 1'b1; m_if.rdata = 32'h3C01_0000;
        step();
        m_if.data_ok = 1'b0; m_if.rdata = 32'd0;
        step();

        // both requesters held, every request accepted, response two cycles later
        do_reset();
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_1000;
        data_if.req = 1'b1; data_if.addr = 32'h8000_2000; data_if.wr = 1'b1; data_if.wdata = 32'hA5A5_0001;
        m_if.addr_ok = 1'b1;
        d1 = 1'b0; d2 = 1'b0;
        for (int c = 0; c < 60 && grants.size() < 10; c++) begin
            m_if.data_ok = d2;
            m_if.rdata = $urandom;
            step();
            d2 = d1; d1 = last_hs;
            if (last_hs) grants.push_back(last_sel);
        end
        check_val("grant_count", 32'(grants.size()), 32'd10);
        for (int i = 0; i < grants.size() && i < 10; i++) check_val("grant_order", 32'(grants[i]), 32'(exp_grants[i]));

        // data locked while address handshake stalls, inst rises a cycle later
        do_reset();
        data_if.req = 1'b1; data_if.addr = 32'h0000_4444;
        inst_if.addr = 32'h0000_5555;
        step();
        inst_if.req = 1'b1;
        step();
        step();
        m_if.addr_ok = 1'b1;
        step();
        data_if.req = 1'b0;
        step();
        inst_if.req = 1'b0; m_if.addr_ok = 1'b0;
        step();

        // FIFO depth limit, same-cycle pop does not free a slot
        do_reset();
        inst_if.req = 1'b1; m_if.addr_ok = 1'b1;
        step(); step(); step();
        m_if.data_ok = 1'b1;
        step();
        m_if.data_ok = 1'b0;
        step();
        inst_if.req = 1'b0;
        m_if.data_ok = 1'b1; step(); step(); step();
        m_if.data_ok = 1'b0;
        step();

        // randomized traffic
        do_reset();
        inst_pend = 1'b0; data_pend = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!inst_pend && ($urandom % 4 != 0)) begin
                inst_pend = 1'b1;
                inst_if.wr = 1'($urandom); inst_if.size = 2'($urandom % 3);
                inst_if.addr = $urandom; inst_if.wdata = $urandom;
            end
            if (!data_pend && ($urandom % 3 != 0)) begin
                data_pend = 1'b1;
                data_if.wr = 1'($urandom); data_if.size = 2'($urandom % 3);
                data_if.addr = $urandom; data_if.wdata = $urandom;
            end
            inst_if.req  = inst_pend;
            data_if.req  = data_pend;
            m_if.addr_ok = ($urandom % 3 != 0);
            m_if.data_ok = (q.size() > 0) && ($urandom % 2 == 1);
            m_if.rdata   = $urandom;
            step();
            if (last_hs && last_sel == 1) inst_pend = 1'b0;
            if (last_hs && last_sel == 2) data_pend = 1'b0;
        end

        // async reset in LOCK_I with one transaction outstanding
        do_reset();
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_0100; m_if.addr_ok = 1'b1;
        step();
        inst_if.addr = 32'h0000_0104; m_if.addr_ok = 1'b0;
        step();
        #2;
        do_reset();
        data_if.req = 1'b1; data_if.addr = 32'h0000_0200;
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_0300;
        step();
        zero_inputs();
        step();
        // orphan response: no data_ok, sticky flag, cleared by reset
        m_if.data_ok = 1'b1;
        step();
        m_if.data_ok = 1'b0;
        step(); step();
        check_val("orphan_sticky", 32'(err_orphan), 32'd1);
        do_reset();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
